// File: rtl/p0008_pkg.sv
// Shared definitions for the window-product search controller.
// Optional feature macro: WINDOW_ZERO_SKIP_EN (see p0008_window_ctrl).
package p0008_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  localparam int DEF_LEN   = 1000;
  localparam int DEF_WIN   = 13;
  localparam int DEF_RES_W = 46;
  localparam int DEF_IDX_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_ROM,
    ST_MUL,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/p0008_digit_rom.sv
// Registered single-read-port digit ROM. Contents come from an ASCII string
// parameter (first character = address 0). Each digit is the low nibble of
// its character, so '0'..'9' give 0..9 and ':'..'?' encode 0xA..0xF.
module p0008_digit_rom
  import p0008_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int IDX_W = DEF_IDX_W,
  parameter logic [8*LEN-1:0] DIGITS = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   addr_i,
  output logic [DIGIT_W-1:0] data_o
);

  localparam logic [IDX_W:0] LEN_W = (IDX_W+1)'(LEN);

  logic [DIGIT_W-1:0] rom [LEN];
  logic [DIGIT_W-1:0] data_q;

  for (genvar i = 0; i < LEN; i++) begin : g_rom
    assign rom[i] = DIGITS[8*(LEN-1-i) +: DIGIT_W];
  end

  // one-cycle registered read; out-of-range addresses read as 0
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if ({1'b0, addr_i} < LEN_W) begin
      data_q <= rom[addr_i];
    end else begin
      data_q <= '0;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/p0008_window_ctrl.sv
// Sequencing controller for the adjacent-digit window-product search.
// Walks every WIN-digit window of a LEN-digit ROM, multiplies the digits via an
// external iterative multiplier and keeps the strict maximum and its start index.
// Optional feature macro: WINDOW_ZERO_SKIP_EN -- a 0 digit skips the rest of
// every window containing it, without issuing a multiply.
//
// Multiplier handshake: mul_req is held high with mul_a/mul_b stable until a
// cycle where mul_ack is also high; that cycle transfers mul_p. mul_ack while
// mul_req is low is ignored. Dropping mul_req on reset is legal.
module p0008_window_ctrl
  import p0008_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int WIN   = DEF_WIN,
  parameter int RES_W = DEF_RES_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [IDX_W-1:0]   digit_addr,
  input  logic [DIGIT_W-1:0] digit_data,
  output logic               mul_req,
  output logic [RES_W-1:0]   mul_a,
  output logic [DIGIT_W-1:0] mul_b,
  input  logic               mul_ack,
  input  logic [RES_W-1:0]   mul_p,
  output logic [RES_W-1:0]   result,
  output logic [IDX_W-1:0]   best_index,
  output logic               busy,
  output logic               done,
  output logic               error,
  output state_t             dbg_state
);

  // last legal window start, one bit wider so base+1 cannot wrap
  localparam logic [IDX_W:0]   LAST_BASE = (IDX_W+1)'(LEN - WIN);
  localparam logic [IDX_W-1:0] J_LAST    = IDX_W'(WIN - 1);
  localparam logic [IDX_W:0]   ONE_W     = (IDX_W+1)'(1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   base_q, base_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [IDX_W-1:0]   best_q, best_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [DIGIT_W-1:0] mul_b_q, mul_b_d;
  logic [IDX_W:0]     base_inc;

  assign base_inc = {1'b0, base_q} + ONE_W;

`ifdef WINDOW_ZERO_SKIP_EN
  logic [IDX_W:0] base_skip;
  // first window start past the zero just read
  assign base_skip = {1'b0, base_q} + {1'b0, j_q} + ONE_W;
`endif

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      best_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      mul_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      best_q   <= best_d;
      done_q   <= done_d;
      error_q  <= error_d;
      mul_b_q  <= mul_b_d;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    j_d      = j_q;
    acc_d    = acc_q;
    result_d = result_q;
    best_d   = best_q;
    done_d   = done_q;
    error_d  = error_q;
    mul_b_d  = mul_b_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          result_d = '0;
          best_d   = '0;
          done_d   = 1'b0;
          error_d  = 1'b0;
          base_d   = '0;
          j_d      = '0;
          acc_d    = RES_W'(1);
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT_ROM;
      end
      ST_WAIT_ROM: begin
        if (digit_data > DIGIT_MAX) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
`ifdef WINDOW_ZERO_SKIP_EN
        end else if (digit_data == '0) begin
          // every window holding this zero has product 0 and cannot win
          base_d = base_skip[IDX_W-1:0];
          j_d    = '0;
          acc_d  = RES_W'(1);
          if (base_skip > LAST_BASE) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
`endif
        end else begin
          mul_b_d = digit_data;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_ack) begin
          acc_d = mul_p;
          if (j_q == J_LAST) begin
            state_d = ST_COMPARE;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_COMPARE: begin
        // strict compare keeps the earliest window on ties
        if (acc_q > result_q) begin
          result_d = acc_q;
          best_d   = base_q;
        end
        base_d = base_inc[IDX_W-1:0];
        j_d    = '0;
        acc_d  = RES_W'(1);
        if (base_inc > LAST_BASE) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign digit_addr = (state_q == ST_FETCH) ? (base_q + j_q) : '0;
  assign mul_req    = (state_q == ST_MUL);
  assign mul_a      = acc_q;
  assign mul_b      = mul_b_q;
  assign result     = result_q;
  assign best_index = best_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = done_q;
  assign error      = error_q;
  assign dbg_state  = state_q;

endmodule
